// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state encoding and the latched command payload
// for the single-outstanding AXI4 master port.
package axi_pkg;

  localparam int unsigned ADDR_BITS    = 32;
  localparam int unsigned DATA_BITS    = 32;
  localparam int unsigned ID_BITS      = 4;
  localparam int unsigned AXI_LEN_BITS = 4;
  localparam int unsigned STRB_BITS    = DATA_BITS / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0]    addr;
    logic [AXI_LEN_BITS-1:0] len;
    logic [1:0]              burst;
  } cmd_t;

endpackage

// File: rtl/axi_master_port_if.sv
// AXI4 master channel bundle (AR/R/AW/W/B) with master and slave views.
interface axi_master_port_if;
  import axi_pkg::*;

  logic [ID_BITS-1:0]      arid;
  logic [ADDR_BITS-1:0]    araddr;
  logic [AXI_LEN_BITS-1:0] arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_BITS-1:0]      rid;
  logic [DATA_BITS-1:0]    rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic [ID_BITS-1:0]      awid;
  logic [ADDR_BITS-1:0]    awaddr;
  logic [AXI_LEN_BITS-1:0] awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_BITS-1:0]    wdata;
  logic [STRB_BITS-1:0]    wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_BITS-1:0]      bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );

endinterface

// File: rtl/axi_master_port.sv
// Single-outstanding AXI4 initiator: one local command becomes one complete
// AR/R or AW/W/B transaction; data flows through valid/ready streams.
module axi_master_port
  import axi_pkg::*;
#(
  parameter int unsigned     ADDR_W = ADDR_BITS,
  parameter int unsigned     DATA_W = DATA_BITS,
  parameter int unsigned     ID_W   = ID_BITS,
  parameter int unsigned     LEN_W  = AXI_LEN_BITS,
  parameter logic [ID_W-1:0] MST_ID = '0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [1:0]        cmd_burst,

  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,

  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,

  output logic              done,
  output logic [1:0]        done_resp,

  axi_master_port_if.master axi
);

  state_t           state, state_n;
  cmd_t             cmd_q, cmd_n;
  logic [LEN_W-1:0] cnt_q, cnt_n;
  logic [1:0]       resp_q, resp_n;
  logic             arvalid_q, awvalid_q, bready_q, in_r_q, in_w_q;
  logic             last_beat_c;
  logic             unused_ids;

  assign last_beat_c = (cnt_q == cmd_q.len);

  // Next-state, counter and response bookkeeping
  always_comb begin
    state_n = state;
    cmd_n   = cmd_q;
    cnt_n   = cnt_q;
    resp_n  = resp_q;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_n.addr  = cmd_addr;
          cmd_n.len   = cmd_len;
          cmd_n.burst = cmd_burst;
          cnt_n       = '0;
          resp_n      = AXI_RESP_OKAY;
          state_n     = cmd_write ? ST_AW : ST_AR;
        end
      end
      ST_AR: if (axi.arready) state_n = ST_R;
      ST_R: begin
        if (axi.rvalid && rd_ready) begin
          cnt_n = cnt_q + LEN_W'(1);
          // Keep only the first error seen in the burst
          if (resp_q == AXI_RESP_OKAY) resp_n = axi.rresp;
          if (axi.rlast) state_n = ST_FIN;
        end
      end
      ST_AW: if (axi.awready) state_n = ST_W;
      ST_W: begin
        if (wr_valid && axi.wready) begin
          cnt_n = cnt_q + LEN_W'(1);
          if (last_beat_c) state_n = ST_B;
        end
      end
      ST_B: begin
        if (axi.bvalid) begin
          resp_n  = axi.bresp;
          state_n = ST_FIN;
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, latched command and per-state control flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      resp_q    <= AXI_RESP_OKAY;
      cmd_ready <= 1'b1;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      in_r_q    <= 1'b0;
      in_w_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_q     <= cmd_n;
      cnt_q     <= cnt_n;
      resp_q    <= resp_n;
      cmd_ready <= (state_n == ST_IDLE);
      arvalid_q <= (state_n == ST_AR);
      awvalid_q <= (state_n == ST_AW);
      bready_q  <= (state_n == ST_B);
      in_r_q    <= (state_n == ST_R);
      in_w_q    <= (state_n == ST_W);
      done      <= (state_n == ST_FIN);
    end
  end

  assign done_resp = resp_q;

  assign axi.arid    = MST_ID;
  assign axi.araddr  = cmd_q.addr;
  assign axi.arlen   = cmd_q.len;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = cmd_q.burst;
  assign axi.arvalid = arvalid_q;

  // Read data is a straight pass-through while in R
  assign rd_data    = axi.rdata;
  assign rd_valid   = in_r_q & axi.rvalid;
  assign axi.rready = in_r_q & rd_ready;

  assign axi.awid    = MST_ID;
  assign axi.awaddr  = cmd_q.addr;
  assign axi.awlen   = cmd_q.len;
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = cmd_q.burst;
  assign axi.awvalid = awvalid_q;

  assign axi.wdata  = wr_data;
  assign axi.wstrb  = '1;
  assign axi.wlast  = in_w_q & last_beat_c;
  assign axi.wvalid = in_w_q & wr_valid;
  assign wr_ready   = in_w_q & axi.wready;

  assign axi.bready = bready_q;

  // Response IDs are deliberately not checked
  assign unused_ids = ^{axi.rid, axi.bid};

endmodule
